// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the
// iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

  function automatic logic is_signed_a(
    input muldiv_op_t op
  );
    return op inside {MD_MUL, MD_MULH,
      MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(
    input muldiv_op_t op
  );
    return op inside {MD_MUL, MD_MULH,
      MD_DIV, MD_REM};
  endfunction

  function automatic logic is_div(
    input muldiv_op_t op
  );
    return op[2];
  endfunction

  function automatic logic is_high(
    input muldiv_op_t op
  );
    return op inside {MD_MULH, MD_MULHSU,
      MD_MULHU};
  endfunction

  function automatic logic is_rem(
    input muldiv_op_t op
  );
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply or
// restoring divide on a {hi, lo} accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;

  always_comb begin
    hi   = acc_in[2*XLEN-1:XLEN];
    lo   = acc_in[XLEN-1:0];
    sum  = {1'b0, hi}
         + (lo[0] ? {1'b0, b} : '0);
    shl  = {hi, lo[XLEN-1]};
    diff = shl - {1'b0, b};
    // divide: hi = remainder, lo = dividend
    // shifting out / quotient shifting in
    if (is_div) begin
      if (diff[XLEN])
        acc_out = {shl[XLEN-1:0],
                   lo[XLEN-2:0], 1'b0};
      else
        acc_out = {diff[XLEN-1:0],
                   lo[XLEN-2:0], 1'b1};
    end else begin
      acc_out = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV M-extension unit: FSM,
// operand prep, fast paths and sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam int W2 = 2 * XLEN;

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    return XLEN'($signed(v));
  endfunction

  muldiv_state_t   state, state_n;
  muldiv_op_t      op_in, op_q;
  logic            w_in, word_q;
  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            sa, sb;
  logic            b_zero, ovf, illegal;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic [W2-1:0]   acc_init;
  logic [W2-1:0]   acc, step_out;
  logic [XLEN-1:0] b_q;
  logic            neg_q, neg_r;
  logic [6:0]      cnt;
  logic            last;
  logic [W2-1:0]   prod, pneg;
  logic [XLEN-1:0] qm, rm, raw, fin;
  logic [XLEN-1:0] result;

  assign op_in = muldiv_op_t'(req_op);
  assign w_in  = (XLEN == 64) && req_word;

  always_comb begin
    a_ext = req_a;
    b_ext = req_b;
    if (w_in) begin
      a_ext = is_signed_a(op_in)
            ? sext32(req_a[31:0])
            : XLEN'(req_a[31:0]);
      b_ext = is_signed_b(op_in)
            ? sext32(req_b[31:0])
            : XLEN'(req_b[31:0]);
    end
    sa    = is_signed_a(op_in) & a_ext[XLEN-1];
    sb    = is_signed_b(op_in) & b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
  end

  always_comb begin
    b_zero  = (b_ext == '0);
    ovf     = is_div(op_in)
            && is_signed_b(op_in) && (&b_ext)
            && (a_ext == (w_in
                 ? sext32(32'h8000_0000)
                 : XLEN'(1) << (XLEN-1)));
    illegal = w_in && is_high(op_in);
    fast    = illegal
            || (FAST_ZERO && is_div(op_in)
                && (b_zero || ovf));
    if (illegal)
      fast_res = '0;
    else if (b_zero)
      fast_res = is_rem(op_in)
               ? (w_in ? sext32(req_a[31:0])
                       : req_a)
               : '1;
    else
      fast_res = is_rem(op_in) ? '0 : a_ext;
    // word divides feed the dividend MSB-first
    if (is_div(op_in) && w_in)
      acc_init = {XLEN'(0),
                  a_mag << (XLEN-32)};
    else
      acc_init = {XLEN'(0), a_mag};
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div(op_q)),
    .acc_in  (acc),
    .b       (b_q),
    .acc_out (step_out)
  );

  assign last = (cnt == (word_q ? 7'd31
                        : 7'(XLEN-1)));

  always_comb begin
    prod = word_q ? step_out >> (XLEN-32)
                  : step_out;
    pneg = neg_q ? -prod : prod;
    qm   = step_out[XLEN-1:0];
    rm   = step_out[W2-1:XLEN];
    if (!is_div(op_q))
      raw = is_high(op_q) ? pneg[W2-1:XLEN]
                          : pneg[XLEN-1:0];
    else if (is_rem(op_q))
      raw = neg_r ? -rm : rm;
    else
      raw = neg_q ? -qm : qm;
    fin = word_q ? sext32(raw[31:0]) : raw;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req_valid)
              state_n = fast ? DONE : CALC;
      CALC: if (last) state_n = DONE;
      DONE: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      b_q    <= '0;
      op_q   <= MD_MUL;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush) begin
      if (state == IDLE && req_valid) begin
        acc    <= acc_init;
        b_q    <= b_mag;
        op_q   <= op_in;
        word_q <= w_in;
        // x/0 keeps an unsigned all-ones quotient
        neg_q  <= (sa ^ sb)
                & ~(is_div(op_in) & b_zero);
        neg_r  <= sa;
        cnt    <= '0;
        if (fast) result <= fast_res;
      end else if (state == CALC) begin
        acc <= step_out;
        cnt <= cnt + 7'd1;
        if (last) result <= fin;
      end
    end
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_result = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: fixed vectors, corner
// sequences and random ops vs a math model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        rv32 = 1'b0, rv64 = 1'b0;
  logic        rr32, rr64, vv32, vv64;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [63:0] req_a = '0, req_b = '0;
  logic        resp_ready = 1'b0;
  logic [31:0] res32;
  logic [63:0] res64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(32)) u32 (
    .clock(clock), .reset_n(reset_n),
    .flush(flush), .req_valid(rv32),
    .req_ready(rr32), .req_op(req_op),
    .req_word(req_word),
    .req_a(req_a[31:0]), .req_b(req_b[31:0]),
    .resp_valid(vv32),
    .resp_ready(resp_ready),
    .resp_result(res32)
  );

  muldiv_unit #(.XLEN(64), .FAST_ZERO(1'b0)) u64 (
    .clock(clock), .reset_n(reset_n),
    .flush(flush), .req_valid(rv64),
    .req_ready(rr64), .req_op(req_op),
    .req_word(req_word),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(vv64),
    .resp_ready(resp_ready),
    .resp_result(res64)
  );

  typedef struct {
    bit          x64;
    logic [2:0]  op;
    bit          word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h",
               name, got, exp);
    end
  endtask

  function automatic bit rdy(input bit x64);
    return x64 ? rr64 : rr32;
  endfunction

  function automatic bit vld(input bit x64);
    return x64 ? vv64 : vv32;
  endfunction

  function automatic logic [63:0] ref_res(
    input bit x64, input logic [2:0] op,
    input bit word,
    input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    bit w32;
    w32 = !x64 || word;
    sa = w32 ? 128'($signed(a[31:0]))
             : 128'($signed(a));
    sb = w32 ? 128'($signed(b[31:0]))
             : 128'($signed(b));
    ua = w32 ? 128'(a[31:0]) : 128'(a);
    ub = w32 ? 128'(b[31:0]) : 128'(b);
    case (op)
      3'd0, 3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: p = (sb == 0) ? -128'sd1 : sa / sb;
      3'd5: p = (ub == 0) ? -128'sd1 : ua / ub;
      3'd6: p = (sb == 0) ? sa : sa % sb;
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    if (op inside {3'd1, 3'd2, 3'd3}) begin
      if (x64 && word) return 64'd0;
      p = p >>> (w32 ? 32 : 64);
    end
    if (!x64) return {32'd0, p[31:0]};
    if (word) return 64'($signed(p[31:0]));
    return p[63:0];
  endfunction

  function automatic int ref_lat(
    input bit x64, input bit fz,
    input logic [2:0] op, input bit word,
    input logic [63:0] a, input logic [63:0] b);
    bit w32;
    bit ovf;
    logic [63:0] am, bm;
    w32 = !x64 || word;
    am = w32 ? {32'd0, a[31:0]} : a;
    bm = w32 ? {32'd0, b[31:0]} : b;
    ovf = (op == 3'd4 || op == 3'd6)
        && bm == (w32 ? 64'hFFFF_FFFF : '1)
        && am == (w32 ? 64'h8000_0000
                      : 64'h8000_0000_0000_0000);
    if (x64 && word && op inside {3'd1, 3'd2, 3'd3})
      return 0;
    if (fz && op[2] && (bm == 0 || ovf))
      return 0;
    return (x64 && !word) ? 64 : 32;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(1, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run(input bit x64,
                     input logic [2:0] op,
                     input bit word,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     output logic [63:0] res,
                     output int lat,
                     output bit busy_ok);
    int t;
    t = 0;
    while (!rdy(x64) && t < 200) begin
      @(posedge clock); #1; t++;
    end
    req_op = op; req_word = word;
    req_a = a; req_b = b;
    if (x64) rv64 = 1'b1; else rv32 = 1'b1;
    @(posedge clock); #1;
    rv32 = 1'b0; rv64 = 1'b0;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_op = 3'($urandom);
    req_word = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!vld(x64) && lat < 200) begin
      if (rdy(x64)) busy_ok = 1'b0;
      @(posedge clock); #1; lat++;
    end
    if (rdy(x64)) busy_ok = 1'b0;
    res = x64 ? res64 : {32'd0, res32};
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic wait_vld32(output int lat);
    lat = 0;
    while (!vv32 && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int lat;
    bit ok;
    bit seen;

    tv.push_back('{0, MD_MUL, 0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 32});
    tv.push_back('{0, MD_MULH, 0, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 32});
    tv.push_back('{0, MD_MULHU, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 32});
    tv.push_back('{0, MD_MULHSU, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32});
    tv.push_back('{0, MD_DIV, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 32});
    tv.push_back('{0, MD_REM, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 32});
    tv.push_back('{0, MD_DIVU, 0, 64'd100, 64'd0, 64'hFFFF_FFFF, 0});
    tv.push_back('{0, MD_REMU, 0, 64'd100, 64'd0, 64'd100, 0});
    tv.push_back('{0, MD_DIV, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0});
    tv.push_back('{0, MD_REM, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0});
    tv.push_back('{0, MD_DIV, 0, 64'hFFFF_FF9C, 64'd0, 64'hFFFF_FFFF, 0});
    tv.push_back('{0, MD_REM, 0, 64'hFFFF_FF9C, 64'd0, 64'hFFFF_FF9C, 0});
    tv.push_back('{1, MD_DIV, 1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32});
    tv.push_back('{1, MD_MUL, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32});
    tv.push_back('{1, MD_MULH, 1, 64'd5, 64'd7, 64'd0, 0});
    tv.push_back('{1, MD_DIV, 0, -64'sd7, 64'd2, -64'sd3, 64});
    tv.push_back('{1, MD_DIV, 0, -64'sd5, 64'd0, '1, 64});
    tv.push_back('{1, MD_REM, 1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 32});
    tv.push_back('{1, MD_DIVU, 1, 64'hFFFF_FFFF_0000_0010, 64'd3, 64'd5, 32});
    tv.push_back('{1, MD_MULHU, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64});

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst rdy32", 64'(rr32), 64'd1);
    chk("rst vld32", 64'(vv32), 64'd0);
    chk("rst res32", 64'(res32), 64'd0);
    chk("rst rdy64", 64'(rr64), 64'd1);
    chk("rst vld64", 64'(vv64), 64'd0);
    chk("rst res64", res64, 64'd0);

    foreach (tv[i]) begin
      run(tv[i].x64, tv[i].op, tv[i].word,
          tv[i].a, tv[i].b, res, lat, ok);
      chk($sformatf("vec%0d res", i),
          res, tv[i].exp);
      chk($sformatf("vec%0d lat", i),
          64'(lat), 64'(tv[i].lat));
      chk($sformatf("vec%0d busy", i),
          64'(ok), 64'd1);
    end

    // back-pressure, then overlap of
    // resp_ready with a new request
    req_op = MD_MUL; req_word = 1'b0;
    req_a = 64'd3; req_b = 64'd5;
    rv32 = 1'b1;
    @(posedge clock); #1;
    rv32 = 1'b0;
    wait_vld32(lat);
    chk("bp lat", 64'(lat), 64'd32);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      if (res32 !== 32'd15 || !vv32 || rr32)
        ok = 1'b0;
    end
    chk("bp stable", 64'(ok), 64'd1);
    req_a = 64'd2; req_b = 64'd3;
    rv32 = 1'b1; resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("ovl idle", {62'd0, vv32, rr32}, 64'd1);
    @(posedge clock); #1;
    rv32 = 1'b0;
    wait_vld32(lat);
    chk("ovl lat", 64'(lat), 64'd32);
    chk("ovl res", 64'(res32), 64'd6);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;

    // flush in the 10th CALC cycle
    req_op = MD_DIV; req_a = 64'd1000;
    req_b = 64'd7; rv32 = 1'b1;
    @(posedge clock); #1;
    rv32 = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("fl idle", {62'd0, vv32, rr32}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (vv32) seen = 1'b1;
    end
    chk("fl noresp", 64'(seen), 64'd0);

    // flush on the accepting edge
    req_op = MD_DIVU; req_b = 64'd0;
    rv32 = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    rv32 = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (vv32 || !rr32) seen = 1'b1;
    end
    chk("fl accept", 64'(seen), 64'd0);

    // async reset mid-CALC
    req_op = MD_MUL; req_a = 64'h1234;
    req_b = 64'h5678; rv32 = 1'b1;
    @(posedge clock); #1;
    rv32 = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("ar vld", 64'(vv32), 64'd0);
    chk("ar res", 64'(res32), 64'd0);
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("ar rdy", 64'(rr32), 64'd1);
    run(0, MD_MULHU, 0, 64'hDEAD_BEEF,
        64'h1234_5678, res, lat, ok);
    chk("ar fresh", res,
        ref_res(0, MD_MULHU, 0, 64'hDEAD_BEEF,
                64'h1234_5678));

    for (int k = 0; k < 80; k++) begin
      bit x64;
      bit word;
      logic [2:0] op;
      logic [63:0] a, b;
      x64  = (k >= 40);
      op   = 3'($urandom_range(0, 7));
      word = 1'($urandom);
      a = pick(); b = pick();
      run(x64, op, word, a, b, res, lat, ok);
      chk($sformatf("rnd%0d res", k), res,
          ref_res(x64, op, word, a, b));
      chk($sformatf("rnd%0d lat", k),
          64'(lat),
          64'(ref_lat(x64, !x64, op, word,
                      a, b)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
